// File: rtl/sevenseg_pkg.sv
// Shared constants and the hex-to-segment decode used by the seven-segment scan driver.
// Segment patterns are active-low, with bit order g..a.
package sevenseg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_scan_driver_scan_timebase.sv
// Refresh divider and digit index counter for the scan driver.
// frame_end marks the terminal-count cycle of the last digit in a frame.
module scan_timebase #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100_000,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int DIV_W = $clog2(REFRESH_DIV)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [IDX_W-1:0] idx,
  output logic             frame_end
);

  logic [DIV_W-1:0] div_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             div_end;

  assign div_end   = (div_reg == DIV_W'(REFRESH_DIV - 1));
  assign frame_end = div_end && (idx_reg == IDX_W'(NUM_DIGITS - 1));
  assign idx       = idx_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_reg <= '0;
      idx_reg <= '0;
    end else if (div_end) begin
      div_reg <= '0;
      idx_reg <= frame_end ? '0 : idx_reg + IDX_W'(1);
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with tear-free loading,
// per-digit decimal point, enable, blink and leading-zero blanking.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lzb,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   display_sel,
  output logic [7:0]              display,
  output logic                    frame_tick
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [IDX_W-1:0] idx;
  logic             frame_end;

  scan_timebase #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_timebase (
    .clock    (clock),
    .reset    (reset),
    .idx      (idx),
    .frame_end(frame_end)
  );

  logic [4*NUM_DIGITS-1:0] value_shadow_reg, value_active_reg;
  logic [NUM_DIGITS-1:0]   dp_shadow_reg, dp_active_reg;
  logic [NUM_DIGITS-1:0]   en_shadow_reg, en_active_reg;
  logic [NUM_DIGITS-1:0]   blink_shadow_reg, blink_active_reg;
  logic                    lzb_shadow_reg, lzb_active_reg;
  logic                    pending_reg;
  logic [BLINK_W-1:0]      blink_cnt_reg;
  logic                    blink_ph_reg;
  logic [NUM_DIGITS-1:0]   display_sel_reg;
  logic [7:0]              display_reg;
  logic                    frame_tick_reg;

  // Active set only changes on a frame boundary, so a frame never mixes old and new data.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_shadow_reg <= '0;
      dp_shadow_reg    <= '0;
      en_shadow_reg    <= '0;
      blink_shadow_reg <= '0;
      lzb_shadow_reg   <= 1'b0;
      value_active_reg <= '0;
      dp_active_reg    <= '0;
      en_active_reg    <= '0;
      blink_active_reg <= '0;
      lzb_active_reg   <= 1'b0;
      pending_reg      <= 1'b0;
    end else begin
      if (load) begin
        value_shadow_reg <= value;
        dp_shadow_reg    <= dp;
        en_shadow_reg    <= digit_en;
        blink_shadow_reg <= blink_en;
        lzb_shadow_reg   <= lzb;
      end
      if (frame_end && load) begin
        value_active_reg <= value;
        dp_active_reg    <= dp;
        en_active_reg    <= digit_en;
        blink_active_reg <= blink_en;
        lzb_active_reg   <= lzb;
        pending_reg      <= 1'b0;
      end else if (frame_end && pending_reg) begin
        value_active_reg <= value_shadow_reg;
        dp_active_reg    <= dp_shadow_reg;
        en_active_reg    <= en_shadow_reg;
        blink_active_reg <= blink_shadow_reg;
        lzb_active_reg   <= lzb_shadow_reg;
        pending_reg      <= 1'b0;
      end else if (load) begin
        pending_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt_reg <= '0;
      blink_ph_reg  <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_reg == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= '0;
        blink_ph_reg  <= ~blink_ph_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
      end
    end
  end

  logic [NUM_DIGITS-1:0] blank;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      logic lz;
      // A digit is a leading zero when it and every more significant nibble are zero.
      if (gi == 0) begin : g_lsd
        assign lz = 1'b0;
      end else begin : g_upper
        assign lz = lzb_active_reg && (value_active_reg[4*NUM_DIGITS-1:4*gi] == '0);
      end
      assign blank[gi] = !en_active_reg[gi] || (blink_active_reg[gi] && blink_ph_reg) || lz;
    end
  endgenerate

  logic [NUM_DIGITS-1:0] display_sel_next;
  logic [7:0]            display_next;

  always_comb begin
    display_sel_next = '1;
    display_next     = SEG_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i) && !blank[i]) begin
        display_sel_next[i] = 1'b0;
        display_next        = {~dp_active_reg[i], hex_to_seg(value_active_reg[4*i +: 4])};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      display_sel_reg <= '1;
      display_reg     <= SEG_BLANK;
      frame_tick_reg  <= 1'b0;
    end else begin
      display_sel_reg <= display_sel_next;
      display_reg     <= display_next;
      frame_tick_reg  <= frame_end;
    end
  end

  assign display_sel = display_sel_reg;
  assign display     = display_reg;
  assign frame_tick  = frame_tick_reg;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver (4 digits, 4-cycle refresh, 2-frame blink) against a
// frame-level reference: each frame shows the newest load issued before that frame began.
module tb_sevenseg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FRAME = ND * RD;

  logic          clock;
  logic          reset;
  logic [15:0]   value;
  logic [3:0]    dp, digit_en, blink_en;
  logic          lzb, load;
  logic [3:0]    display_sel;
  logic [7:0]    display;
  logic          frame_tick;

  sevenseg_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .dp         (dp),
    .digit_en   (digit_en),
    .blink_en   (blink_en),
    .lzb        (lzb),
    .load       (load),
    .display_sel(display_sel),
    .display    (display),
    .frame_tick (frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         p;
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [3:0]  bl;
    logic        lz;
  } load_t;

  load_t      loads[$];
  logic [6:0] seg_tab[16];
  int         p;
  int         checks;
  int         fails;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (pos %0d)", tag, obs, exp, p);
    end
  endtask

  // One clock edge: record what the DUT sampled, then compare its registered outputs.
  task automatic tick();
    logic       rst_edge;
    int         q, fr, d;
    load_t      c;
    logic [15:0] sh;
    logic       blanked;
    logic [3:0] exp_sel;
    logic [7:0] exp_disp;
    logic       exp_tick;
    @(posedge clock);
    rst_edge = reset;
    if (rst_edge) begin
      p = 0;
      loads.delete();
    end else begin
      if (load) loads.push_back('{p, value, dp, digit_en, blink_en, lzb});
      p++;
    end
    #1;
    if (rst_edge) begin
      exp_sel  = 4'hF;
      exp_disp = 8'hFF;
      exp_tick = 1'b0;
    end else begin
      q  = p - 1;
      fr = q / FRAME;
      d  = (q / RD) % ND;
      c  = '{0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      foreach (loads[k]) if (loads[k].p <= fr * FRAME - 1) c = loads[k];
      sh = c.v >> (4 * d);
      blanked = !c.en[d] || (c.bl[d] && ((fr / BF) % 2 == 1)) || (c.lz && d >= 1 && sh == 16'h0);
      exp_sel  = blanked ? 4'hF : ~(4'b0001 << d);
      exp_disp = blanked ? 8'hFF : {~c.dp[d], seg_tab[sh[3:0]]};
      exp_tick = (q % FRAME) == FRAME - 1;
    end
    check("sel", {4'h0, display_sel}, {4'h0, exp_sel});
    check("display", display, exp_disp);
    check("frame_tick", {7'h0, frame_tick}, {7'h0, exp_tick});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en,
                         input logic [3:0] bl, input logic lz);
    value = v; dp = d; digit_en = en; blink_en = bl; lzb = lz; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic align(input int phase);
    int n = 0;
    while (p % FRAME != phase && n < 2 * FRAME) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_sel(input string tag, input logic [3:0] target, input logic [7:0] exp_disp);
    int n = 0;
    while (display_sel !== target && n < 64) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 64) else begin
      fails++;
      $error("FAIL %s_timeout: observed sel %b expected %b", tag, display_sel, target);
    end
    check(tag, display, exp_disp);
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    checks = 0; fails = 0; p = 0;
    reset = 1'b1; load = 1'b0; value = '0; dp = '0; digit_en = '0; blink_en = '0; lzb = 1'b0;
    run(3);
    reset = 1'b0;
    run(5);

    do_load(16'h12AF, 4'h0, 4'hF, 4'h0, 1'b0);
    wait_sel("digit0_F", 4'b1110, 8'h8E);
    wait_sel("digit1_A", 4'b1101, 8'h88);
    wait_sel("digit2_2", 4'b1011, 8'hA4);
    wait_sel("digit3_1", 4'b0111, 8'hF9);
    run(2 * FRAME);

    do_load(16'h0000, 4'h0, 4'hF, 4'h0, 1'b1);
    run(20);
    wait_sel("lzb_zero", 4'b1110, 8'hC0);
    run(FRAME);
    do_load(16'h0050, 4'h0, 4'hF, 4'h0, 1'b1);
    run(20);
    wait_sel("lzb_d1", 4'b1101, 8'h92);
    wait_sel("lzb_d0", 4'b1110, 8'hC0);
    run(FRAME);

    do_load(16'h3333, 4'b0100, 4'hF, 4'h0, 1'b0);
    run(20);
    wait_sel("dp_d2", 4'b1011, 8'h30);
    wait_sel("dp_d3", 4'b0111, 8'hB0);

    do_load(16'h3333, 4'h0, 4'hF, 4'b0001, 1'b0);
    run(6 * FRAME);

    align(5);
    do_load(16'h1111, 4'h0, 4'hF, 4'h0, 1'b0);
    tick();
    do_load(16'h2222, 4'h0, 4'hF, 4'h0, 1'b0);
    run(2 * FRAME);
    align(FRAME - 1);
    do_load(16'h9876, 4'h0, 4'hF, 4'h0, 1'b0);
    wait_sel("boundary_load", 4'b1110, 8'h82);

    align(3);
    do_load(16'h5555, 4'hF, 4'hF, 4'h0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(2 * FRAME);
    do_load(16'h0000, 4'h0, 4'hF, 4'h0, 1'b0);
    run(20);
    wait_sel("post_reset_d3", 4'b0111, 8'hC0);

    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        logic [15:0] v;
        for (int j = 0; j < 4; j++) v[4*j +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        do_load(v, 4'($urandom), 4'($urandom) | 4'($urandom), 4'($urandom) & 4'($urandom),
                1'($urandom));
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
